uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with configurable word length and stop bits, input synchroniser, falling-edge start detection with false-start rejection, sticky framing/overrun error flags and a first-word-fall-through receive FIFO. It replaces the fixed 8N1 single-register receiver at the host-link input of the OFDM FPGA design. Parity checking is compile-time optional. The FIFO lets the consumer fall several words behind without loss.

## Interface
- CLK_FREQ, 27_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s; BIT_CYCLE = CLK_FREQ/BAUD_RATE, HALF_CYCLE = BIT_CYCLE/2 (integer division)
- DATA_BITS, 8, word length, legal 5..9, LSB first on the line
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, receive FIFO depth, power of two, at least 2
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rx_pin  input  1  serial line, idle high, asynchronous to clk
- parity_mode  input  2  00/11 none, 01 even, 10 odd; sampled only in IDLE (present only with UART_RX_PARITY_EN)
- data  output  DATA_BITS  FIFO head word, valid while available=1
- available  output  1  FIFO not empty
- read  input  1  pop FIFO head this cycle; ignored when available=0
- frame_err  output  1  sticky: a sampled stop bit was 0
- parity_err  output  1  sticky: parity mismatch; constant 0 without UART_RX_PARITY_EN
- overrun  output  1  sticky: completed word dropped because FIFO full
- clear_err  input  1  clears all sticky error flags

## Operation
- rx_pin passes a 2-FF synchroniser (both FFs reset to 1); all logic below uses the synchronised value rxs and its previous value.
- State machine: IDLE, START, DATA, PARITY, STOP. Bit counter counts cycles 0..BIT_CYCLE-1; width $clog2(BIT_CYCLE).
- IDLE: on rxs falling edge (previous 1, now 0) -> START, counter 0. A line held low does not start a frame; a 1 must be seen first.
- START: sample rxs when counter reaches HALF_CYCLE-1. If 1 -> IDLE (false start, nothing recorded). If 0 -> DATA, counter 0.
- DATA: sample every BIT_CYCLE cycles into shift register, LSB first; after DATA_BITS samples -> PARITY if parity enabled and parity_mode is 01/10, else STOP.
- PARITY: one sample; mismatch against even/odd of the data bits sets parity_err.
- STOP: STOP_BITS samples; any 0 sets frame_err. On the last stop sample the word is pushed into the FIFO (even with frame/parity error) and state -> IDLE immediately, so a start edge in the second half of the stop bit is caught.
- FIFO: first-word-fall-through; data = head, available = not empty. Push when full drops the word and sets overrun. Push and read on the same cycle while full: both succeed, no overrun. Push and read while holding one word: head advances to the new word.
- Sticky flags: set on event, cleared by clear_err; simultaneous set and clear -> flag stays 1.
- Break (line low for a whole frame): word 0 pushed, frame_err set, then IDLE waits for the line to return high.

## Timing
- Reset values: data 0, available 0, frame_err 0, parity_err 0, overrun 0; state IDLE, FIFO empty, synchroniser 1.
- Reset mid-frame: frame and FIFO contents discarded; nothing is pushed after release.
- Start sample occurs HALF_CYCLE cycles after the rxs falling edge; each later sample is BIT_CYCLE cycles after the previous one.
- The push occurs at the clock edge of the last stop sample; available=1 and data valid in the cycle after that edge.
- Total from rxs fall to push edge: HALF_CYCLE + (DATA_BITS + P + STOP_BITS)*BIT_CYCLE cycles, P = 1 if parity is active, else 0. Add 2 cycles from rx_pin.
- read pops at the clock edge; the next word (or available=0) is visible in the cycle after that edge.

## Configuration
- UART_RX_PARITY_EN defined: parity_mode port, PARITY state and parity_err logic are present.
- UART_RX_PARITY_EN undefined: no parity_mode port, frames never contain a parity bit, parity_err is tied to 0.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CYCLE 10, HALF_CYCLE 5), DATA_BITS 8, STOP_BITS 1, FIFO_DEPTH 4.
- Send 0xA5 8N1, no read -> available=1 with data=0xA5 exactly 2+5+9*10 cycles after the start edge; no error flags.
- Send 5 words 0x01..0x05 with no read -> FIFO holds 0x01..0x04, overrun=1; 4 reads return 0x01..0x04, then available=0.
- Low glitch of 3 cycles on an idle line -> returns to IDLE, no push, no flags.
- Stop bit driven 0 on word 0x3C -> 0x3C pushed, frame_err=1; clear_err pulse -> frame_err=0.
- With parity enabled and parity_mode=01, send 0x07 with parity bit 0 -> parity_err=1, data=0x07; same word with parity bit 1 -> no error.
- Assert rst_n low during bit 4 of a frame -> all outputs at reset values; after release the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (5..9 data bits, 1 or 2 stop bits) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add the parity_mode port, the PARITY state and parity_err.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
`ifdef UART_RX_PARITY_EN
    input  logic [1:0]           parity_mode,
`endif
    output logic [DATA_BITS-1:0] data,
    output logic                 available,
    input  logic                 read,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clear_err
);
    localparam int BIT_CYCLE  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLE = BIT_CYCLE / 2;
    localparam int CW = (BIT_CYCLE > 1) ? $clog2(BIT_CYCLE) : 1;
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        bit_idx, bit_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 push, frame_set;
    logic                 sync1, rxs, rxs_prev;

    // Two-stage synchroniser plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= rx_pin;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic [1:0] mode_q, mode_next;
    logic       parity_set;
    logic       parity_active;
    assign parity_active = (mode_q == 2'b01) || (mode_q == 2'b10);
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        bit_next   = bit_idx;
        shreg_next = shreg;
        push       = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        mode_next  = mode_q;
        parity_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                mode_next = parity_mode;
`endif
                // Counter starts at 1: detection happens one cycle after rxs fell.
                if (rxs_prev && !rxs) begin
                    state_next = START;
                    cnt_next   = CW'(1);
                end
            end
            START: begin
                if (cnt == CW'(HALF_CYCLE - 1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CW'(BIT_CYCLE - 1)) begin
                    cnt_next   = '0;
                    shreg_next = {rxs, shreg[DATA_BITS-1:1]};
                    bit_next   = bit_idx + IW'(1);
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        bit_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next = parity_active ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CW'(BIT_CYCLE - 1)) begin
                    cnt_next   = '0;
                    parity_set = ((^shreg) ^ rxs) != (mode_q == 2'b10);
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CW'(BIT_CYCLE - 1)) begin
                    cnt_next  = '0;
                    frame_set = !rxs;
                    bit_next  = bit_idx + IW'(1);
                    // Back to IDLE at once so an early next start edge is not missed.
                    if (bit_idx == IW'(STOP_BITS - 1)) begin
                        push       = 1'b1;
                        bit_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

    // Receive FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, do_pop, do_push, overrun_set;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop      = read && !empty;
    assign do_push     = push && (!full || do_pop);
    assign overrun_set = push && full && !do_pop;
    assign available   = !empty;
    assign data        = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Sticky flags: a set in the same cycle as clear_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set   | (frame_err & ~clear_err);
            overrun   <= overrun_set | (overrun & ~clear_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            parity_err <= 1'b0;
        end else begin
            mode_q     <= mode_next;
            parity_err <= parity_set | (parity_err & ~clear_err);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
